// File: rtl/change_dispenser.sv
// Pays out the accepted change amount as high-value coins first, then low-value coins,
// one eject pulse plus settle gap per coin; stalls in SELECT while the ejector is not ready.
module change_dispenser #(
   parameter int WIDTH        = 8,
   parameter int COIN_HI      = 10,
   parameter int COIN_LO      = 1,
   parameter int PULSE_CYCLES = 4,
   parameter int GAP_CYCLES   = 2
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] amount,
   input  logic             start,
   input  logic             hi_empty,
   input  logic             eject_ready,
   output logic             eject_hi,
   output logic             eject_lo,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] remaining,
   output logic [WIDTH-1:0] hi_count,
   output logic [WIDTH-1:0] lo_count
);

   localparam int CMAX = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
   localparam int CW   = $clog2(CMAX + 1);

   localparam logic [WIDTH-1:0] HI_V     = WIDTH'(COIN_HI);
   localparam logic [WIDTH-1:0] LO_V     = WIDTH'(COIN_LO);
   localparam logic [WIDTH-1:0] ONE_V    = WIDTH'(1);
   localparam logic [CW-1:0]    PULSE_LD = CW'(PULSE_CYCLES - 1);
   localparam logic [CW-1:0]    GAP_LD   = CW'(GAP_CYCLES - 1);
   localparam logic [CW-1:0]    CNT_ONE  = CW'(1);

   typedef enum logic [2:0] {
      IDLE,
      SELECT,
      PULSE,
      GAP,
      DONE
   } state_t;

   state_t           state, state_nxt;
   logic [CW-1:0]    cnt, cnt_nxt;
   logic [WIDTH-1:0] remaining_nxt, hi_count_nxt, lo_count_nxt;
   logic             eject_hi_nxt, eject_lo_nxt;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         cnt       <= '0;
         eject_hi  <= 1'b0;
         eject_lo  <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         remaining <= '0;
         hi_count  <= '0;
         lo_count  <= '0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         eject_hi  <= eject_hi_nxt;
         eject_lo  <= eject_lo_nxt;
         busy      <= (state_nxt != IDLE);
         done      <= (state_nxt == DONE);
         remaining <= remaining_nxt;
         hi_count  <= hi_count_nxt;
         lo_count  <= lo_count_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      cnt_nxt       = cnt;
      remaining_nxt = remaining;
      hi_count_nxt  = hi_count;
      lo_count_nxt  = lo_count;
      eject_hi_nxt  = 1'b0;
      eject_lo_nxt  = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               remaining_nxt = amount;
               hi_count_nxt  = '0;
               lo_count_nxt  = '0;
               state_nxt     = (amount != '0) ? SELECT : DONE;
            end
         end
         SELECT: begin
            if (remaining == '0) begin
               state_nxt = DONE;
            end else if (eject_ready) begin
               // The >= compare guards the subtraction, so remaining cannot wrap.
               if (remaining >= HI_V && !hi_empty) begin
                  remaining_nxt = remaining - HI_V;
                  hi_count_nxt  = hi_count + ONE_V;
                  eject_hi_nxt  = 1'b1;
               end else begin
                  remaining_nxt = remaining - LO_V;
                  lo_count_nxt  = lo_count + ONE_V;
                  eject_lo_nxt  = 1'b1;
               end
               cnt_nxt   = PULSE_LD;
               state_nxt = PULSE;
            end
         end
         PULSE: begin
            // The eject line selected on entry is held until the counter expires.
            if (cnt == '0) begin
               cnt_nxt   = GAP_LD;
               state_nxt = GAP;
            end else begin
               cnt_nxt      = cnt - CNT_ONE;
               eject_hi_nxt = eject_hi;
               eject_lo_nxt = eject_lo;
            end
         end
         GAP: begin
            if (cnt == '0) begin
               state_nxt = SELECT;
            end else begin
               cnt_nxt = cnt - CNT_ONE;
            end
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: per-payout monitor records pulse order, widths,
// done timing and the coin-sum invariant, then compares against hand-computed values.
module tb_change_dispenser;

   localparam int WIDTH = 8;
   localparam int HI    = 10;
   localparam int PULSE = 4;
   localparam int GAP   = 2;

   logic             clock;
   logic             reset;
   logic [WIDTH-1:0] amount;
   logic             start;
   logic             hi_empty;
   logic             eject_ready;
   logic             eject_hi;
   logic             eject_lo;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] remaining;
   logic [WIDTH-1:0] hi_count;
   logic [WIDTH-1:0] lo_count;

   int checks = 0;
   int errs   = 0;

   // monitor results
   int m_done_cyc, m_hi, m_lo, m_first, m_width_err, m_both_err, m_inv_err, m_busy_err;
   int m_rem_c1, m_rem_done, m_after_done, m_after_busy;
   logic [63:0] m_seq;
   int stall_err;

   change_dispenser #(
      .WIDTH(WIDTH), .COIN_HI(HI), .COIN_LO(1), .PULSE_CYCLES(PULSE), .GAP_CYCLES(GAP)
   ) dut (
      .clock(clock), .reset(reset), .amount(amount), .start(start),
      .hi_empty(hi_empty), .eject_ready(eject_ready),
      .eject_hi(eject_hi), .eject_lo(eject_lo), .busy(busy), .done(done),
      .remaining(remaining), .hi_count(hi_count), .lo_count(lo_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errs++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Presents amount with start for exactly one rising edge (E0); returns #1 after E0.
   task automatic kick(input int amt);
      @(negedge clock);
      amount = amt[WIDTH-1:0];
      start  = 1'b1;
      @(posedge clock);
      #1 start = 1'b0;
   endtask

   // Samples cycle k (k=1 is the cycle after E0) at each falling edge until done or budget.
   task automatic monitor(input int amt, input int max_cyc);
      int   run;
      logic prev_hi, prev_lo;
      m_done_cyc = -1; m_hi = 0; m_lo = 0; m_first = -1; m_seq = '0;
      m_width_err = 0; m_both_err = 0; m_inv_err = 0; m_busy_err = 0;
      m_rem_c1 = -1; m_rem_done = -1; m_after_done = -1; m_after_busy = -1;
      run = 0; prev_hi = 1'b0; prev_lo = 1'b0;
      for (int k = 1; k <= max_cyc && m_done_cyc < 0; k++) begin
         @(negedge clock);
         if (k == 1) m_rem_c1 = int'(remaining);
         if (!busy) m_busy_err++;
         if (eject_hi && eject_lo) m_both_err++;
         if (int'(hi_count) * HI + int'(lo_count) + int'(remaining) != amt) m_inv_err++;
         if (eject_hi && !prev_hi) begin
            m_hi++; m_seq = {m_seq[62:0], 1'b1};
            if (m_first < 0) m_first = k;
         end
         if (eject_lo && !prev_lo) begin
            m_lo++; m_seq = {m_seq[62:0], 1'b0};
            if (m_first < 0) m_first = k;
         end
         if (eject_hi || eject_lo) run++;
         else begin
            if (run != 0 && run != PULSE) m_width_err++;
            run = 0;
         end
         prev_hi = eject_hi; prev_lo = eject_lo;
         if (done) begin
            m_done_cyc = k;
            m_rem_done = int'(remaining);
         end
      end
      if (m_done_cyc > 0) begin
         @(negedge clock);
         m_after_done = int'(done);
         m_after_busy = int'(busy);
      end
   endtask

   task automatic check_common(input string tag, input int done_cyc, input int n_hi, input int n_lo,
                               input int seq, input int rem1);
      chk({tag, " done_cycle"}, m_done_cyc, done_cyc);
      chk({tag, " hi_pulses"}, m_hi, n_hi);
      chk({tag, " lo_pulses"}, m_lo, n_lo);
      chk({tag, " order"}, int'(m_seq), seq);
      chk({tag, " hi_count"}, int'(hi_count), n_hi);
      chk({tag, " lo_count"}, int'(lo_count), n_lo);
      chk({tag, " rem_cycle1"}, m_rem_c1, rem1);
      chk({tag, " rem_at_done"}, m_rem_done, 0);
      chk({tag, " width_err"}, m_width_err, 0);
      chk({tag, " both_err"}, m_both_err, 0);
      chk({tag, " invariant_err"}, m_inv_err, 0);
      chk({tag, " busy_err"}, m_busy_err, 0);
      chk({tag, " done_after"}, m_after_done, 0);
      chk({tag, " busy_after"}, m_after_busy, 0);
   endtask

   initial begin
      reset = 1'b0; amount = '0; start = 1'b0; hi_empty = 1'b0; eject_ready = 1'b1;
      #1;
      chk("rst eject_hi", int'(eject_hi), 0);
      chk("rst busy", int'(busy), 0);
      chk("rst done", int'(done), 0);
      chk("rst remaining", int'(remaining), 0);
      repeat (3) @(negedge clock);
      reset = 1'b1;

      // Reset asserted mid-pulse: eject drops without a clock edge.
      kick(23);
      repeat (3) @(negedge clock);
      chk("midpulse eject_hi", int'(eject_hi), 1);
      #2 reset = 1'b0;
      #1;
      chk("async eject_hi", int'(eject_hi), 0);
      chk("async eject_lo", int'(eject_lo), 0);
      chk("async busy", int'(busy), 0);
      chk("async remaining", int'(remaining), 0);
      chk("async hi_count", int'(hi_count), 0);
      chk("async lo_count", int'(lo_count), 0);
      repeat (2) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      chk("post_rst idle busy", int'(busy), 0);
      kick(11);
      monitor(11, 300);
      check_common("after_rst 11", 16, 1, 1, 2, 11);

      // 23 -> hi,hi,lo,lo,lo; done in cycle 37.
      kick(23);
      monitor(23, 300);
      check_common("amt23", 37, 2, 3, 24, 23);

      // Zero amount: straight to done in cycle 1.
      kick(0);
      monitor(0, 50);
      check_common("amt0", 1, 0, 0, 0, 0);

      // High tube empty throughout.
      hi_empty = 1'b1;
      kick(15);
      monitor(15, 300);
      check_common("amt15 empty", 107, 0, 15, 0, 15);

      // High tube refilled before the first SELECT sample.
      kick(15);
      hi_empty = 1'b0;
      monitor(15, 300);
      check_common("amt15 refill", 44, 1, 5, 32, 15);

      // Ejector stalled for 10 cycles in the first SELECT.
      eject_ready = 1'b0;
      stall_err = 0;
      kick(12);
      fork
         monitor(12, 300);
         begin
            for (int i = 0; i < 10; i++) begin
               @(negedge clock);
               if (!busy || remaining != 8'd12 || eject_hi || eject_lo) stall_err++;
            end
            @(posedge clock);
            #1 eject_ready = 1'b1;
         end
      join
      chk("stall hold_err", stall_err, 0);
      chk("stall first_pulse", m_first, 12);
      check_common("amt12 stall", 33, 1, 2, 4, 12);

      // Start re-asserted with a new amount during PULSE is ignored.
      kick(20);
      fork
         monitor(20, 300);
         begin
            repeat (3) @(negedge clock);
            amount = 8'd99;
            start  = 1'b1;
            @(posedge clock);
            @(posedge clock);
            #1 start = 1'b0;
         end
      join
      check_common("amt20 restart", 16, 2, 0, 3, 20);

      // A fresh start after done loads the new amount.
      kick(7);
      monitor(7, 300);
      check_common("amt7 new", 51, 0, 7, 0, 7);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
